// File: rtl/ins_fetch_queue.sv
// Instruction fetch front end: owns the fetch PC, issues in-order IMEM reads and
// buffers returned words. Define FETCH_BYPASS_EN for a same-cycle response bypass.
module ins_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        SYS_clk,
  input  logic        SYS_reset,
  output logic        IMEM_req_valid,
  input  logic        IMEM_req_ready,
  output logic [31:0] IMEM_req_addr,
  input  logic        IMEM_rsp_valid,
  input  logic [31:0] IMEM_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_PC,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] instruction,
  output logic [31:0] PC,
  output logic        fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_data_mem [DEPTH];
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_pq_mem   [DEPTH];
  logic [AW-1:0] r_rd_ptr, r_wr_ptr;
  logic [AW-1:0] r_pq_rd, r_pq_wr;
  logic [CW-1:0] r_count, r_inflight, r_drop;
  logic          r_fault;

  logic [CW:0]   w_occupancy;
  logic          w_req_valid, w_req_hs;
  logic          w_rsp_live, w_fifo_valid, w_bypass, w_push, w_pop;
  logic [31:0]   w_rsp_pc;

  // Buffered words plus every outstanding request (including ones to be dropped)
  // reserve FIFO slots, so a returning word always has room.
  assign w_occupancy  = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_req_valid  = SYS_reset && !r_fault && (w_occupancy < DEPTH_W) && !redirect_valid;
  assign w_req_hs     = w_req_valid && IMEM_req_ready;
  assign w_rsp_live   = IMEM_rsp_valid && (r_drop == '0);
  assign w_rsp_pc     = r_pq_mem[r_pq_rd];
  assign w_fifo_valid = !r_fault && (r_count != '0);

`ifdef FETCH_BYPASS_EN
  assign w_bypass = (r_count == '0) && w_rsp_live && !r_fault && !redirect_valid;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop  = w_fifo_valid && ins_ready;
  assign w_push = w_rsp_live && !redirect_valid && !(w_bypass && ins_ready);

  assign IMEM_req_valid = w_req_valid;
  assign IMEM_req_addr  = r_fetch_pc;
  assign ins_valid      = w_fifo_valid || w_bypass;
  assign fetch_fault    = r_fault;

  // NOTE: every output gets a default before the branches, otherwise always_comb infers a latch.
  always_comb begin
    instruction = '0;
    PC          = '0;
    if (w_fifo_valid) begin
      instruction = r_data_mem[r_rd_ptr];
      PC          = r_pc_mem[r_rd_ptr];
    end
`ifdef FETCH_BYPASS_EN
    else if (w_bypass) begin
      instruction = IMEM_rsp_data;
      PC          = w_rsp_pc;
    end
`endif
  end

  // NOTE: storage arrays are not reset; pointers and count decide what is valid,
  // and outputs are masked to zero when nothing is valid.
  always_ff @(posedge SYS_clk) begin
    if (w_push) begin
      r_data_mem[r_wr_ptr] <= IMEM_rsp_data;
      r_pc_mem[r_wr_ptr]   <= w_rsp_pc;
    end
    if (w_req_hs) begin
      r_pq_mem[r_pq_wr] <= r_fetch_pc;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      r_fetch_pc <= RESET_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_pq_rd    <= '0;
      r_pq_wr    <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_fault    <= 1'b0;
    end else if (redirect_valid) begin
      // A response landing this cycle is already accounted for; the rest get dropped.
      r_fetch_pc <= redirect_PC;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_pq_rd    <= '0;
      r_pq_wr    <= '0;
      r_count    <= '0;
      r_inflight <= r_inflight - CW'(IMEM_rsp_valid);
      r_drop     <= r_inflight - CW'(IMEM_rsp_valid);
      r_fault    <= |redirect_PC[1:0];
    end else begin
      if (w_req_hs) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_pq_wr    <= r_pq_wr + 1'b1;
      end
      if (w_rsp_live) r_pq_rd <= r_pq_rd + 1'b1;
      if (w_push)     r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)      r_rd_ptr <= r_rd_ptr + 1'b1;
      if (IMEM_rsp_valid && (r_drop != '0)) r_drop <= r_drop - 1'b1;
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      r_inflight <= r_inflight + CW'(w_req_hs) - CW'(IMEM_rsp_valid);
    end
  end

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Self-checking bench for ins_fetch_queue: directed scenarios plus randomized traffic
// against an epoch-based memory/stream model.
module tb_ins_fetch_queue;

  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        SYS_clk, SYS_reset;
  logic        IMEM_req_valid, IMEM_req_ready;
  logic [31:0] IMEM_req_addr;
  logic        IMEM_rsp_valid;
  logic [31:0] IMEM_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_PC;
  logic        ins_valid, ins_ready;
  logic [31:0] instruction, PC;
  logic        fetch_fault;

  ins_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .SYS_clk(SYS_clk), .SYS_reset(SYS_reset),
    .IMEM_req_valid(IMEM_req_valid), .IMEM_req_ready(IMEM_req_ready),
    .IMEM_req_addr(IMEM_req_addr),
    .IMEM_rsp_valid(IMEM_rsp_valid), .IMEM_rsp_data(IMEM_rsp_data),
    .redirect_valid(redirect_valid), .redirect_PC(redirect_PC),
    .ins_valid(ins_valid), .ins_ready(ins_ready),
    .instruction(instruction), .PC(PC), .fetch_fault(fetch_fault)
  );

  initial SYS_clk = 1'b0;
  always #5 SYS_clk = ~SYS_clk;

  typedef struct {
    int          due;
    logic [31:0] addr;
    int          epoch;
  } mem_t;

  mem_t        mem_q[$];
  logic [31:0] buf_q[$];
  logic [31:0] m_req_pc;
  bit          m_fault;
  int          m_epoch;

  int tests, fails, cyc, issued, consumed;
  int lat_min, lat_max, rr_pct, ir_pct, redir_pct;
  bit force_redir, force_pop, want_first;
  logic [31:0] force_target, first_pc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_clear();
    mem_q.delete();
    buf_q.delete();
    m_req_pc   = RESET_PC;
    m_fault    = 1'b0;
    m_epoch    = 0;
    want_first = 1'b0;
  endtask

  task automatic do_reset();
    SYS_reset      = 1'b0;
    redirect_valid = 1'b0;
    redirect_PC    = '0;
    IMEM_rsp_valid = 1'b0;
    IMEM_rsp_data  = '0;
    IMEM_req_ready = 1'b0;
    ins_ready      = 1'b0;
    repeat (2) @(posedge SYS_clk);
    #1;
    check("rst_req_valid", IMEM_req_valid, 0);
    check("rst_ins_valid", ins_valid, 0);
    check("rst_fault", fetch_fault, 0);
    check("rst_instruction", instruction, 0);
    check("rst_pc", PC, 0);
    model_clear();
    SYS_reset = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: drive at posedge+1, check and update the model at negedge.
  task automatic step();
    bit          redir, rsp, live, byp, exp_rv, exp_iv;
    logic [31:0] tgt, rsp_addr, exp_pc;
    mem_t        e;

    redir = 1'b0;
    tgt   = $urandom;
    if (force_redir) begin
      redir = 1'b1; tgt = force_target; force_redir = 1'b0;
    end else if ($urandom_range(99) < redir_pct) begin
      redir = 1'b1;
      tgt   = $urandom & 32'h0000_3FFC;
      if ($urandom_range(4) == 0) tgt[1:0] = 2'($urandom_range(3, 1));
    end
    redirect_valid = redir;
    redirect_PC    = tgt;
    ins_ready      = force_pop || ($urandom_range(99) < ir_pct);
    force_pop      = 1'b0;
    IMEM_req_ready = $urandom_range(99) < rr_pct;
    rsp      = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    rsp_addr = rsp ? mem_q[0].addr : 32'h0;
    IMEM_rsp_valid = rsp;
    IMEM_rsp_data  = rsp ? word(rsp_addr) : $urandom;
    #4;

    live   = rsp && (mem_q[0].epoch == m_epoch);
    exp_rv = !m_fault && (buf_q.size() + mem_q.size() < DEPTH) && !redir;
    byp    = BYP && (buf_q.size() == 0) && live && !m_fault && !redir;
    exp_iv = !m_fault && ((buf_q.size() > 0) || byp);
    exp_pc = (buf_q.size() > 0) ? buf_q[0] : rsp_addr;
    check("req_valid", IMEM_req_valid, exp_rv);
    check("ins_valid", ins_valid, exp_iv);
    check("fetch_fault", fetch_fault, m_fault);
    if (exp_iv && ins_valid) begin
      check("pc", PC, exp_pc);
      check("instruction", instruction, word(exp_pc));
    end

    if (rsp) void'(mem_q.pop_front());
    if (IMEM_req_valid && IMEM_req_ready) begin
      check("req_addr", IMEM_req_addr, m_req_pc);
      issued++;
      e.due   = cyc + int'($urandom_range(lat_max, lat_min));
      e.addr  = m_req_pc;
      e.epoch = m_epoch;
      mem_q.push_back(e);
      m_req_pc += 32'd4;
    end

    if (redir) begin
      buf_q.delete();
      m_epoch++;
      m_req_pc   = tgt;
      m_fault    = |tgt[1:0];
      want_first = 1'b1;
      first_pc   = 32'hDEAD_BEEF;
    end else begin
      if (live) buf_q.push_back(rsp_addr);
      if (exp_iv && ins_ready) begin
        if (want_first) begin first_pc = exp_pc; want_first = 1'b0; end
        void'(buf_q.pop_front());
        consumed++;
      end
    end

    @(posedge SYS_clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic knobs(input int lmin, input int lmax, input int rr, input int ir, input int rd);
    lat_min = lmin; lat_max = lmax; rr_pct = rr; ir_pct = ir; redir_pct = rd;
  endtask

  initial begin
    int base;
    tests = 0; fails = 0; issued = 0; consumed = 0;
    force_redir = 1'b0; force_pop = 1'b0; force_target = '0; first_pc = '0;
    knobs(1, 1, 100, 100, 0);

    // Streaming with a 1-cycle memory: one instruction per cycle.
    do_reset();
    consumed = 0;
    run(20);
    check("throughput_ge17", 32'(consumed >= 17), 1);

    // Downstream stalled: DEPTH requests, then exactly one more after a pop.
    knobs(1, 1, 100, 0, 0);
    do_reset();
    issued = 0;
    run(10);
    check("stall_issued", issued, DEPTH);
    force_pop = 1'b1;
    run(6);
    check("stall_issued_after_pop", issued, DEPTH + 1);

    // Slow memory, two in flight, redirect to 0x100.
    knobs(3, 3, 100, 100, 0);
    do_reset();
    run(2);
    force_redir = 1'b1; force_target = 32'h0000_0100;
    run(14);
    check("late_rsp_dropped", first_pc, 32'h0000_0100);

    // Redirect coinciding with the only in-flight response.
    knobs(1, 1, 100, 100, 0);
    do_reset();
    run(3);
    force_redir = 1'b1; force_target = 32'h0000_0040;
    run(8);
    check("redir_with_rsp", first_pc, 32'h0000_0040);

    // Misaligned redirect faults; an aligned one recovers.
    force_redir = 1'b1; force_target = 32'h0000_0102;
    run(1);
    base = issued;
    run(6);
    check("fault_no_requests", issued, base);
    check("fault_flag", fetch_fault, 1);
    force_redir = 1'b1; force_target = 32'h0000_0200;
    run(8);
    check("fault_recovered", first_pc, 32'h0000_0200);

    // PC wrap at the top of the address space.
    force_redir = 1'b1; force_target = 32'hFFFF_FFF8;
    run(10);
    check("wrap_first", first_pc, 32'hFFFF_FFF8);

    // Randomized traffic with redirects and faults.
    knobs(1, 4, 70, 70, 3);
    run(2000);
    knobs(1, 2, 90, 50, 0);
    run(300);

    // Reset in the middle of traffic, then resume.
    knobs(1, 3, 80, 80, 2);
    do_reset();
    run(500);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
